peak_rate_meter: RTL and testbench

- Parametrised successor to the fixed 128-deep slope-window peak finder and the 10 s peak counter; merges both into one block.
- Consumes filtered samples qualified by a strobe in the clk domain and emits a one-cycle peak pulse, the beat interval in samples, and a heart rate per measurement window.
- Adds programmable window depth and thresholds, a hold-off timer and saturating counters, plus continuous or single-shot measurement.
- Sits between the FIR filter output and the seven-segment/LED display logic.

---
 rtl/peakdet_pkg.sv | 35 +++
 rtl/peak_rate_meter_if.sv | 36 +++
 rtl/slope_window.sv | 64 ++++++
 rtl/peak_rate_meter.sv | 250 +++++++++++++++++++++++++
 tb/tb_peak_rate_meter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/peakdet_pkg.sv
// ---------------------------------------------------------------------------
// peakdet_pkg
// Shared types and helpers for the peak_rate_meter block.
//   state_t   : measurement FSM encoding (IDLE / MEASURE / DONE)
//   sum_width : width of a slope-window half sum for a given window depth
//   sat_mul   : multiply with saturation to a given result width
// ---------------------------------------------------------------------------
package peakdet_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   // A half sum counts up to WIN/2 ones, so $clog2(WIN)+1 bits always fits.
   function automatic int sum_width(input int win);
      return $clog2(win) + 1;
   endfunction

   // a*b clamped to 2^rate_w-1; rate_w is expected to be <= 32.
   function automatic logic [31:0] sat_mul(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          rate_w);
      logic [63:0] prod;
      logic [63:0] lim;
      prod = {32'd0, a} * {32'd0, b};
      lim  = (64'd1 << rate_w) - 64'd1;
      if (prod > lim) begin
         return lim[31:0];
      end
      return prod[31:0];
   endfunction

endpackage

// File: rtl/peak_rate_meter_if.sv
// ---------------------------------------------------------------------------
// peak_rate_meter_if
// Filtered-sample stream into the peak/rate meter.
//   sample_valid : one-cycle strobe, sample is valid in that cycle
//   sample       : filtered sample (unsigned, DATA_W bits)
//   min_amp      : minimum running maximum for a peak (only when
//                  PEAKDET_AMP_GATE_EN is defined)
// Handshake: strobe-only stream. The producer asserts sample_valid for one
// cycle per sample (back-to-back cycles allowed); there is no ready, the
// consumer always accepts. master = producer, slave = the meter.
// ---------------------------------------------------------------------------
interface peak_rate_meter_if #(
   parameter int DATA_W = 10
);
   logic              sample_valid;
   logic [DATA_W-1:0] sample;
`ifdef PEAKDET_AMP_GATE_EN
   logic [DATA_W-1:0] min_amp;
`endif

   modport master (
      output sample_valid,
      output sample
`ifdef PEAKDET_AMP_GATE_EN
      , output min_amp
`endif
   );

   modport slave (
      input sample_valid,
      input sample
`ifdef PEAKDET_AMP_GATE_EN
      , input min_amp
`endif
   );
endinterface

// File: rtl/slope_window.sv
// ---------------------------------------------------------------------------
// slope_window
// Slope history shift register with incrementally maintained half sums.
//   clk, reset : clock, synchronous active-low reset
//   step       : advance the window by one bit this cycle
//   bit_in     : new slope bit (shifted into bit 0)
//   left_sum   : ones in the older half  [WIN-1:WIN/2]
//   right_sum  : ones in the recent half [WIN/2-1:0]
// Reset fills the history with ones so both sums start at WIN/2.
// ---------------------------------------------------------------------------
module slope_window
   import peakdet_pkg::*;
#(
   parameter  int WIN   = 128,
   localparam int SUM_W = sum_width(WIN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             bit_in,
   output logic [SUM_W-1:0] left_sum,
   output logic [SUM_W-1:0] right_sum
);

   localparam int               HALF     = WIN / 2;
   localparam logic [SUM_W-1:0] HALF_SUM = SUM_W'(HALF);

   logic [WIN-1:0]   hist_q,  hist_d;
   logic [SUM_W-1:0] left_q,  left_d;
   logic [SUM_W-1:0] right_q, right_d;
   logic             mid_bit;
   logic             old_bit;

   // Sums are updated from the pre-shift history: the bit leaving the right
   // half enters the left half, the oldest bit leaves the window.
   always_comb begin
      hist_d  = hist_q;
      left_d  = left_q;
      right_d = right_q;
      mid_bit = hist_q[HALF-1];
      old_bit = hist_q[WIN-1];
      if (step) begin
         hist_d  = {hist_q[WIN-2:0], bit_in};
         right_d = right_q + SUM_W'(bit_in) - SUM_W'(mid_bit);
         left_d  = left_q + SUM_W'(mid_bit) - SUM_W'(old_bit);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hist_q  <= '1;
         left_q  <= HALF_SUM;
         right_q <= HALF_SUM;
      end else begin
         hist_q  <= hist_d;
         left_q  <= left_d;
         right_q <= right_d;
      end
   end

   assign left_sum  = left_q;
   assign right_sum = right_q;

endmodule

// File: rtl/peak_rate_meter.sv
// ---------------------------------------------------------------------------
// peak_rate_meter
// Slope-window peak detector plus windowed heart-rate measurement.
// Optional build macro: PEAKDET_AMP_GATE_EN (amplitude gate on peaks).
//   clk, reset     : clock, synchronous active-low reset
//   smp            : sample stream (peak_rate_meter_if.slave)
//   continuous     : 1 = restart measurement automatically, 0 = single-shot
//   restart        : one-cycle pulse, leaves DONE in single-shot mode
//   peak           : one-cycle pulse on a detected peak
//   peak_count     : peaks since reset, saturating at 255
//   interval       : samples between the last two peaks
//   interval_valid : one-cycle pulse when interval updates
//   heart_rate     : last computed rate (window peaks * BPM_MULT, saturated)
//   rate_valid     : one-cycle pulse when heart_rate updates
//   meas_active    : high while the FSM is in MEASURE
//   state_dbg      : current measurement FSM state
// ---------------------------------------------------------------------------
module peak_rate_meter
   import peakdet_pkg::*;
#(
   parameter int DATA_W       = 10,
   parameter int WIN          = 128,
   parameter int LEFT_MAX     = 40,
   parameter int RIGHT_MIN    = 38,
   parameter int HOLDOFF      = 127,
   parameter int IGNORE_PEAKS = 3,
   parameter int MEAS_CYCLES  = 400000000,
   parameter int BPM_MULT     = 6,
   parameter int RATE_W       = 12,
   parameter int INT_W        = 16
) (
   input  logic               clk,
   input  logic               reset,
   peak_rate_meter_if.slave   smp,
   input  logic               continuous,
   input  logic               restart,
   output logic               peak,
   output logic [7:0]         peak_count,
   output logic [INT_W-1:0]   interval,
   output logic               interval_valid,
   output logic [RATE_W-1:0]  heart_rate,
   output logic               rate_valid,
   output logic               meas_active,
   output state_t             state_dbg
);

   localparam int SUM_W = sum_width(WIN);
   localparam int HO_W  = $clog2(HOLDOFF + 2);
   localparam int CYC_W = $clog2(MEAS_CYCLES + 1);

   // ---------------- slope window ----------------
   logic [DATA_W-1:0] prev_q, prev_d;
   logic              slope_bit;
   logic [SUM_W-1:0]  left_sum;
   logic [SUM_W-1:0]  right_sum;

   assign slope_bit = (smp.sample <= prev_q);
   assign prev_d    = smp.sample_valid ? smp.sample : prev_q;

   slope_window #(.WIN(WIN)) u_window (
      .clk       (clk),
      .reset     (reset),
      .step      (smp.sample_valid),
      .bit_in    (slope_bit),
      .left_sum  (left_sum),
      .right_sum (right_sum)
   );

   // ---------------- peak detection ----------------
   // step_q marks the cycle in which the registered sums first include the
   // latest sample; the test happens then and peak follows one cycle later,
   // giving two cycles from sample_valid to peak.
   logic            step_q;
   logic [HO_W-1:0] holdoff_q, holdoff_d;
   logic            amp_ok;
   logic            hit;

`ifdef PEAKDET_AMP_GATE_EN
   logic [DATA_W-1:0] max_q, max_d;

   // Running maximum since the last peak; a sample arriving in the hit
   // cycle already belongs to the next beat.
   always_comb begin
      max_d = max_q;
      if (hit) begin
         max_d = smp.sample_valid ? smp.sample : '0;
      end else if (smp.sample_valid && (smp.sample > max_q)) begin
         max_d = smp.sample;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         max_q <= '0;
      end else begin
         max_q <= max_d;
      end
   end

   assign amp_ok = (max_q >= smp.min_amp);
`else
   assign amp_ok = 1'b1;
`endif

   assign hit = step_q
             && (32'(left_sum) <= 32'(LEFT_MAX))
             && (32'(right_sum) >= 32'(RIGHT_MIN))
             && (holdoff_q == '0)
             && amp_ok;

   // A hit reloads the hold-off; otherwise it counts down once per step.
   always_comb begin
      holdoff_d = holdoff_q;
      if (hit) begin
         holdoff_d = HO_W'(HOLDOFF);
      end else if (step_q && (holdoff_q != '0)) begin
         holdoff_d = holdoff_q - HO_W'(1);
      end
   end

   // ---------------- interval and peak count ----------------
   logic [INT_W-1:0] int_cnt_q,  int_cnt_d;
   logic [INT_W-1:0] interval_q, interval_d;
   logic [7:0]       pcount_q,   pcount_d;
   logic             peak_q;
   logic             iv_q;

   always_comb begin
      int_cnt_d  = int_cnt_q;
      interval_d = interval_q;
      pcount_d   = pcount_q;
      if (hit) begin
         interval_d = int_cnt_q;
         int_cnt_d  = INT_W'(1);
         if (pcount_q != 8'hFF) begin
            pcount_d = pcount_q + 8'd1;
         end
      end else if (smp.sample_valid && (int_cnt_q != '1)) begin
         int_cnt_d = int_cnt_q + INT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_q     <= '0;
         step_q     <= 1'b0;
         holdoff_q  <= '0;
         int_cnt_q  <= '0;
         interval_q <= '0;
         pcount_q   <= '0;
         peak_q     <= 1'b0;
         iv_q       <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         step_q     <= smp.sample_valid;
         holdoff_q  <= holdoff_d;
         int_cnt_q  <= int_cnt_d;
         interval_q <= interval_d;
         pcount_q   <= pcount_d;
         peak_q     <= hit;
         iv_q       <= hit;
      end
   end

   // ---------------- measurement FSM ----------------
   state_t            state_q, state_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic [CYC_W-1:0]  win_q, win_d;
   logic [CYC_W-1:0]  win_peaks;
   logic [RATE_W-1:0] hr_q, hr_d;
   logic              rv_q, rv_d;
   logic              last_cyc;
   logic              meas_act;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (32'(pcount_q) >= 32'(IGNORE_PEAKS)) state_d = MEASURE;
         MEASURE: if (last_cyc) state_d = DONE;
         DONE:    if (continuous || restart) state_d = MEASURE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      meas_act = (state_q == MEASURE);
      last_cyc = meas_act && (cyc_q == CYC_W'(MEAS_CYCLES - 1));
   end

   // Window counters and rate; a peak on the final cycle still counts.
   always_comb begin
      cyc_d     = cyc_q;
      win_d     = win_q;
      hr_d      = hr_q;
      rv_d      = 1'b0;
      win_peaks = win_q + CYC_W'(peak_q);
      case (state_q)
         MEASURE: begin
            if (last_cyc) begin
               hr_d = RATE_W'(sat_mul(32'(win_peaks), 32'(BPM_MULT), RATE_W));
               rv_d = 1'b1;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
               win_d = win_peaks;
            end
         end
         default: begin
            if (state_d == MEASURE) begin
               cyc_d = '0;
               win_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cyc_q <= '0;
         win_q <= '0;
         hr_q  <= '0;
         rv_q  <= 1'b0;
      end else begin
         cyc_q <= cyc_d;
         win_q <= win_d;
         hr_q  <= hr_d;
         rv_q  <= rv_d;
      end
   end

   assign peak           = peak_q;
   assign peak_count     = pcount_q;
   assign interval       = interval_q;
   assign interval_valid = iv_q;
   assign heart_rate     = hr_q;
   assign rate_valid     = rv_q;
   assign meas_active    = meas_act;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_peak_rate_meter.sv
// Directed bench: two meters share one sample stream; dut_b differs only in
// RATE_W=4 so its heart_rate saturates. Pattern period is 50 samples:
// 8 rising samples, then 42 non-rising ones. With WIN=16, LEFT_MAX=2,
// RIGHT_MIN=6 the condition is first met on the 6th non-rising sample
// (pattern index 13), so each period yields exactly one peak.
module tb_peak_rate_meter;
  import peakdet_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic continuous = 1'b0;
  logic restart = 1'b0;

  always #5 clk = ~clk;

  peak_rate_meter_if #(.DATA_W(10)) smp_if ();

  logic        peak_a, iv_a, rv_a, meas_a;
  logic [7:0]  pc_a;
  logic [15:0] interval_a;
  logic [11:0] hr_a;
  state_t      st_a;
  logic        peak_b, iv_b, rv_b, meas_b;
  logic [7:0]  pc_b;
  logic [15:0] interval_b;
  logic [3:0]  hr_b;
  state_t      st_b;

  peak_rate_meter #(.DATA_W(10), .WIN(16), .LEFT_MAX(2), .RIGHT_MIN(6),
    .HOLDOFF(4), .IGNORE_PEAKS(3), .MEAS_CYCLES(1000), .BPM_MULT(6),
    .RATE_W(12), .INT_W(16)) dut_a (
    .clk(clk), .reset(reset), .smp(smp_if), .continuous(continuous),
    .restart(restart), .peak(peak_a), .peak_count(pc_a),
    .interval(interval_a), .interval_valid(iv_a), .heart_rate(hr_a),
    .rate_valid(rv_a), .meas_active(meas_a), .state_dbg(st_a));

  peak_rate_meter #(.DATA_W(10), .WIN(16), .LEFT_MAX(2), .RIGHT_MIN(6),
    .HOLDOFF(4), .IGNORE_PEAKS(3), .MEAS_CYCLES(1000), .BPM_MULT(6),
    .RATE_W(4), .INT_W(16)) dut_b (
    .clk(clk), .reset(reset), .smp(smp_if), .continuous(continuous),
    .restart(restart), .peak(peak_b), .peak_count(pc_b),
    .interval(interval_b), .interval_valid(iv_b), .heart_rate(hr_b),
    .rate_valid(rv_b), .meas_active(meas_b), .state_dbg(st_b));

  int err_cnt = 0;
  int chk_cnt = 0;

  // Edge counter and output monitor
  int pcyc = 0;
  int n_peak = 0, n_iv = 0, n_meas = 0, n_rv = 0, n_rv_b = 0;
  int last_peak_edge = 0, mark_edge = 0;
  logic [15:0] last_iv = '0;
  logic meas_at_rv = 1'b0, meas_after_rv = 1'b0, rv_pending = 1'b0;
  logic [15:0] exp_q[$];

  always @(posedge clk) pcyc = pcyc + 1;

  always @(negedge clk) begin
    if (peak_a) begin n_peak = n_peak + 1; last_peak_edge = pcyc; end
    if (iv_a) begin n_iv = n_iv + 1; last_iv = interval_a; end
    if (meas_a) n_meas = n_meas + 1;
    if (rv_pending) begin meas_after_rv = meas_a; rv_pending = 1'b0; end
    if (rv_a) begin n_rv = n_rv + 1; meas_at_rv = meas_a; rv_pending = 1'b1; end
    if (rv_b) n_rv_b = n_rv_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed_const(input logic [9:0] v, input int count);
    for (int i = 0; i < count; i++) begin
      smp_if.sample_valid = 1'b1;
      smp_if.sample = v;
      @(posedge clk); #1;
    end
    smp_if.sample_valid = 1'b0;
  endtask

  task automatic feed_pattern(input int start, input int count);
    int ph;
    for (int i = start; i < start + count; i++) begin
      ph = i % 50;
      smp_if.sample_valid = 1'b1;
      smp_if.sample = (ph < 8) ? 10'(210 + 10 * ph) : 10'd200;
      if (i == 13) mark_edge = pcyc;
      @(posedge clk); #1;
    end
    smp_if.sample_valid = 1'b0;
  endtask

  task automatic wait_rv(input int base, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      settle();
      if (n_rv > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int base_peak, base_iv, base_meas, base_rv, base_rv_b;
    bit ok;
    logic [15:0] exp_iv;
    smp_if.sample_valid = 1'b0;
    smp_if.sample = '0;
`ifdef PEAKDET_AMP_GATE_EN
    smp_if.min_amp = '0;
`endif

    // Reset state
    do_reset();
    settle();
    check("rst_peak", 32'(peak_a), 0);
    check("rst_peak_count", 32'(pc_a), 0);
    check("rst_interval", 32'(interval_a), 0);
    check("rst_interval_valid", 32'(iv_a), 0);
    check("rst_heart_rate", 32'(hr_a), 0);
    check("rst_rate_valid", 32'(rv_a), 0);
    check("rst_meas_active", 32'(meas_a), 0);
    check("rst_state", 32'(st_a), 32'(IDLE));

    // Constant input never forms a peak
    base_peak = n_peak; base_iv = n_iv;
    feed_const(10'd100, 200);
    idle(4);
    settle();
    check("const_peaks", n_peak - base_peak, 0);
    check("const_peak_count", 32'(pc_a), 0);
    check("const_interval_valid", n_iv - base_iv, 0);
    check("const_heart_rate", 32'(hr_a), 0);

    // 8 rising then 8 falling: one peak, two cycles after sample index 13
    do_reset();
    base_peak = n_peak;
    feed_pattern(0, 16);
    idle(10);
    settle();
    check("tri_peaks", n_peak - base_peak, 1);
    check("tri_latency", last_peak_edge - mark_edge, 2);
    check("tri_peak_count", 32'(pc_a), 1);

    // Two peaks 50 samples apart
    do_reset();
    base_iv = n_iv;
    exp_q.push_back(16'd50);
    feed_pattern(0, 100);
    idle(5);
    settle();
    check("iv_count", n_iv - base_iv, 2);
    exp_iv = exp_q.pop_front();
    check("iv_value", 32'(last_iv), 32'(exp_iv));
    check("iv_peak_count", 32'(pc_a), 2);

    // Measurement window: 3 ignored peaks, then 5 peaks in the window
    do_reset();
    continuous = 1'b0;
    base_meas = n_meas; base_rv = n_rv; base_rv_b = n_rv_b;
    feed_pattern(0, 400);
    wait_rv(base_rv, 3000, ok);
    check("rate_timeout", 32'(ok), 1);
    idle(20);
    settle();
    check("meas_cycles", n_meas - base_meas, 1000);
    check("rate_pulses", n_rv - base_rv, 1);
    check("rate_pulses_b", n_rv_b - base_rv_b, 1);
    check("heart_rate", 32'(hr_a), 30);
    check("heart_rate_sat", 32'(hr_b), 15);
    check("win_peak_count", 32'(pc_a), 8);
    check("single_shot_hold", 32'(st_a), 32'(DONE));
    check("single_shot_meas", 32'(meas_a), 0);

    // restart leaves DONE on the next cycle
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    settle();
    check("restart_meas", 32'(meas_a), 1);

    // Reset in the middle of MEASURE
    idle(10);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    settle();
    check("midrst_heart_rate", 32'(hr_a), 0);
    check("midrst_meas", 32'(meas_a), 0);
    check("midrst_peak_count", 32'(pc_a), 0);
    check("midrst_state", 32'(st_a), 32'(IDLE));

    // Continuous mode after reset: history must be back to all ones
    continuous = 1'b1;
    base_rv = n_rv;
    feed_pattern(0, 16);
    idle(3);
    settle();
    check("cont_latency", last_peak_edge - mark_edge, 2);
    @(posedge clk); #1;
    feed_pattern(16, 134);
    settle();
    check("cont_peak_count", 32'(pc_a), 3);
    wait_rv(base_rv, 3000, ok);
    check("cont_timeout", 32'(ok), 1);
    settle();
    check("cont_heart_rate", 32'(hr_a), 0);
    check("cont_meas_at_rv", 32'(meas_at_rv), 0);
    check("cont_reenter", 32'(meas_after_rv), 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
